// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small circular transmit FIFO.
// Frames are sent LSB first, back to back while bytes remain queued; serial_out is registered.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_load,
    output logic       serial_out,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]     count_reg, count_next;
    logic [CW-1:0]   clk_cnt_reg, clk_cnt_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            serial_out_reg, serial_out_next;
    logic            tx_done_reg, tx_done_next;
    logic            fifo_empty, wr_en, pop, bit_end;

    assign fifo_empty = (count_reg == '0);
    assign tx_ready   = (count_reg != FIFO_FULL);
    assign wr_en      = data_load && tx_ready;
    assign bit_end    = (clk_cnt_reg == CNT_LAST);
    assign tx_busy    = !((state_reg == IDLE) && fifo_empty);
    assign serial_out = serial_out_reg;
    assign tx_done    = tx_done_reg;

    // Storage has no reset so it maps onto plain RAM; the head byte is registered into shift_reg on pop.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            fifo_mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            clk_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            serial_out_reg <= 1'b1;
            tx_done_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            clk_cnt_reg    <= clk_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            serial_out_reg <= serial_out_next;
            tx_done_reg    <= tx_done_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr_reg];
                    bit_cnt_next = '0;
                    clk_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        shift_next   = fifo_mem[rd_ptr_reg];
                        bit_cnt_next = '0;
                        state_next   = START;
                    end else begin
                        state_next   = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + (PW + 1)'(1);
        end else if (!wr_en && pop) begin
            count_next = count_reg - (PW + 1)'(1);
        end
    end

    // Line level follows the state being entered so it changes on the same edge as the state.
    always_comb begin
        serial_out_next = 1'b1;
        case (state_next)
            START:   serial_out_next = 1'b0;
            DATA:    serial_out_next = shift_next[0];
            default: serial_out_next = 1'b1;
        endcase
        tx_done_next = (state_reg == STOP) && bit_end;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed vector table, hand-written corner sequences,
// and random traffic compared every cycle against a frame-level reference model.
module tb_uart_transmitter;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_load = 1'b0;
    logic       serial_out, tx_ready, tx_busy, tx_done;

    uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_load(data_load),
        .serial_out(serial_out), .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cycles[$];
    logic [7:0] rx_q[$];

    // Reference model: a byte queue plus the position inside the frame currently on the line.
    logic [7:0] mq[$];
    int         pos = -1;
    logic [7:0] cur = 8'h00;
    bit         m_done = 1'b0;

    task automatic model_edge(input bit rst_n, input bit ld, input logic [7:0] d);
        bit acc;
        if (!rst_n) begin
            mq.delete();
            pos = -1;
            m_done = 1'b0;
            return;
        end
        acc = ld && (mq.size() < DEPTH);
        m_done = 1'b0;
        if (pos == FRAME - 1) begin
            m_done = 1'b1;
            pos = -1;
        end else if (pos >= 0) begin
            pos++;
        end
        if (pos < 0 && mq.size() > 0) begin
            cur = mq.pop_front();
            pos = 0;
        end
        if (acc) mq.push_back(d);
    endtask

    function automatic logic m_serial();
        int k;
        if (pos < 0) return 1'b1;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    task automatic check_model();
        logic [3:0] got, exp;
        got = {serial_out, tx_ready, tx_busy, tx_done};
        exp = {m_serial(), (mq.size() < DEPTH) ? 1'b1 : 1'b0,
               (pos >= 0 || mq.size() > 0) ? 1'b1 : 1'b0, m_done};
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL model cyc=%0d ser/rdy/busy/done got=%b expected=%b", cyc, got, exp);
        end
    endtask

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, actual, expected);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        bit bad;
        bad = (rx_q.size() != exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            if (rx_q[i] !== exp[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s got %0d bytes %p expected %0d bytes %p", name, rx_q.size(), rx_q, exp.size(), exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit ld, input logic [7:0] d);
        reset = rst_n;
        data_load = ld;
        data_in = d;
        @(posedge clk);
        model_edge(rst_n, ld, d);
        #1;
        cyc++;
        check_model();
        if (tx_done === 1'b1) done_cycles.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    // Line decoder: samples each bit in the middle of its period.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (serial_out === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = serial_out;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
                $display("rx byte 0x%02h stop=%b at cycle %0d", b, serial_out, cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    typedef struct {
        bit         rst_n;
        bit         ld;
        logic [7:0] din;
        int         rep;
        bit         e_ser;
        bit         e_rdy;
        bit         e_busy;
        bit         e_done;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [7:0] a5;
        logic [7:0] exp_q[$];
        int idx;
        a5 = 8'hA5;
        // Reset with a write held high, then single byte 0xA5 from idle.
        vecs[0]  = '{1'b0, 1'b1, 8'h33, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 3, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++)
            vecs[5+k] = '{1'b1, 1'b0, 8'h00, 4, a5[k], 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1, 1'b1, 1'b1, 1'b0, 1'b0};

        for (int v = 0; v < 16; v++) begin
            for (int r = 0; r < vecs[v].rep; r++) step(vecs[v].rst_n, vecs[v].ld, vecs[v].din);
            $display("vector %0d applied x%0d ser=%b rdy=%b busy=%b done=%b", v, vecs[v].rep,
                     serial_out, tx_ready, tx_busy, tx_done);
            check($sformatf("vec%0d serial_out", v), serial_out, vecs[v].e_ser);
            check($sformatf("vec%0d tx_ready", v), tx_ready, vecs[v].e_rdy);
            check($sformatf("vec%0d tx_busy", v), tx_busy, vecs[v].e_busy);
            check($sformatf("vec%0d tx_done", v), tx_done, vecs[v].e_done);
        end
        check_int("single tx_done count", done_cycles.size(), 1);
        idle(4);
        exp_q = '{8'hA5};
        check_rx("single rx", exp_q);

        // Back-to-back frames.
        rx_q.delete(); done_cycles.delete();
        step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'h0F);
        idle(100);
        check_int("b2b tx_done count", done_cycles.size(), 2);
        if (done_cycles.size() == 2)
            check_int("b2b tx_done spacing", done_cycles[1] - done_cycles[0], FRAME);
        exp_q = '{8'h55, 8'h0F};
        check_rx("b2b rx", exp_q);

        // Overflow: sixth byte dropped.
        rx_q.delete();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1, 8'(i));
            if (i >= 5) check($sformatf("overflow tx_ready after load %0d", i), tx_ready, 1'b0);
        end
        idle(5 * FRAME + 20);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("overflow rx", exp_q);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        idle(15);
        step(1'b0, 1'b0, 8'h00);
        check("midreset serial_out", serial_out, 1'b1);
        check("midreset tx_busy", tx_busy, 1'b0);
        check("midreset tx_ready", tx_ready, 1'b1);
        done_cycles.delete();
        idle(60);
        check_int("midreset tx_done count", done_cycles.size(), 0);
        rx_q.delete();

        // Write on the STOP-completion edge while full.
        step(1'b1, 1'b1, 8'h21);
        for (int i = 2; i <= 5; i++) step(1'b1, 1'b1, 8'(8'h20 + i));
        idle(36);
        check("collision pre tx_ready", tx_ready, 1'b0);
        check("collision pre serial_out", serial_out, 1'b1);
        step(1'b1, 1'b1, 8'h77);
        check("collision tx_done", tx_done, 1'b1);
        check("collision next start", serial_out, 1'b0);
        check("collision post tx_ready", tx_ready, 1'b1);
        idle(4 * FRAME + 20);
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        check_rx("collision rx", exp_q);

        // Pointer wrap: 12 bytes streamed while the FIFO stays below full.
        rx_q.delete();
        idx = 0;
        while (idx < 12) begin
            if (mq.size() < DEPTH - 1) begin
                step(1'b1, 1'b1, 8'(8'h10 + idx));
                idx++;
            end else begin
                step(1'b1, 1'b0, 8'($urandom));
            end
        end
        idle(5 * FRAME);
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(8'(8'h10 + i));
        check_rx("wrap rx", exp_q);

        // Random traffic, with rare resets and data_in changing freely.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) == 0), 8'($urandom));
        idle(5 * FRAME);
        rx_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
